// File: rtl/counter_pkg.sv
// Shared counter constants: default watchdog timeout and the counter width it needs.
// No logic; latency not applicable.
// No handshake; constants only.
package counter_pkg;

    localparam int WDT_TIMEOUT = 1000;
    localparam int WDT_WIDTH   = $clog2(WDT_TIMEOUT);

endpackage : counter_pkg

// File: rtl/up_counter.sv
// Up-counter with programmable step, terminal count, wrap/saturate and sticky overflow.
// Latency: one cycle; outputs are registered and reflect the inputs of the previous rising edge.
// No backpressure: en is sampled every edge, priority rstn > clear > en > hold.
module up_counter #(
    parameter int WIDTH          = 10,
    parameter int INCREMENT_RATE = 1,
    parameter int MAX_COUNT      = (2**WIDTH) - 1,
    parameter bit SATURATE       = 1'b0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             clear,
    output logic             overflow,
    output logic [WIDTH-1:0] count_val
);

    if (WIDTH < 1) begin : g_chk_width
        $fatal(1, "up_counter: WIDTH must be >= 1");
    end
    if (INCREMENT_RATE < 1 || INCREMENT_RATE > MAX_COUNT) begin : g_chk_rate
        $fatal(1, "up_counter: INCREMENT_RATE must be within 1..MAX_COUNT");
    end
    if (longint'(MAX_COUNT) >= (longint'(1) << WIDTH)) begin : g_chk_max
        $fatal(1, "up_counter: MAX_COUNT must be below 2**WIDTH");
    end

    localparam logic [WIDTH:0]   RATE_EXT = (WIDTH+1)'(INCREMENT_RATE);
    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MAX_COUNT);
    // Modulus low bits; zero when MAX_COUNT is the full range, which makes the wrap a plain truncation.
    localparam logic [WIDTH-1:0] WRAP_LO  = WIDTH'(longint'(MAX_COUNT) + 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH:0]   sum;

    always_comb begin
        sum        = {1'b0, count_q} + RATE_EXT;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (clear) begin
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (en) begin
            if (sum > {1'b0, MAX_VAL}) begin
                overflow_d = 1'b1;
                // sum - (MAX_COUNT+1) is always below 2**WIDTH, so the low bits are exact.
                count_d    = SATURATE ? MAX_VAL : (sum[WIDTH-1:0] - WRAP_LO);
            end else begin
                count_d = sum[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign count_val = count_q;
    assign overflow  = overflow_q;

endmodule : up_counter

// File: tb/tb_up_counter.sv
// Directed bench for up_counter: four configurations share one set of control inputs.
// Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
module tb_up_counter;

    logic clk;
    logic rstn;
    logic en;
    logic clear;

    logic       ovf_w4,  ovf_r3,  ovf_sat, ovf_wdt;
    logic [3:0] cnt_w4,  cnt_r3,  cnt_sat;
    logic [counter_pkg::WDT_WIDTH-1:0] cnt_wdt;

    int checks;
    int errors;

    up_counter #(.WIDTH(4), .INCREMENT_RATE(1)) u_w4 (
        .clk(clk), .rstn(rstn), .en(en), .clear(clear),
        .overflow(ovf_w4), .count_val(cnt_w4)
    );

    up_counter #(.WIDTH(4), .INCREMENT_RATE(3), .MAX_COUNT(9), .SATURATE(1'b0)) u_r3 (
        .clk(clk), .rstn(rstn), .en(en), .clear(clear),
        .overflow(ovf_r3), .count_val(cnt_r3)
    );

    up_counter #(.WIDTH(4), .INCREMENT_RATE(3), .MAX_COUNT(9), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rstn(rstn), .en(en), .clear(clear),
        .overflow(ovf_sat), .count_val(cnt_sat)
    );

    up_counter #(
        .WIDTH(counter_pkg::WDT_WIDTH),
        .INCREMENT_RATE(1),
        .MAX_COUNT(counter_pkg::WDT_TIMEOUT - 1)
    ) u_wdt (
        .clk(clk), .rstn(rstn), .en(en), .clear(clear),
        .overflow(ovf_wdt), .count_val(cnt_wdt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn  = 1'b0;
        en    = 1'b0;
        clear = 1'b0;
        step();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn  = 1'b0;
        en    = 1'b1;
        clear = 1'b0;
        step();
        checks++;
        if (cnt_w4 !== 4'd0 || ovf_w4 !== 1'b0) begin
            errors++;
            $display("FAIL reset_w4: count=%0d ovf=%b, expected count=0 ovf=0", cnt_w4, ovf_w4);
        end
        checks++;
        if (cnt_r3 !== 4'd0 || ovf_r3 !== 1'b0 || cnt_sat !== 4'd0 || ovf_sat !== 1'b0) begin
            errors++;
            $display("FAIL reset_r3_sat: r3=%0d/%b sat=%0d/%b, expected 0/0 0/0",
                     cnt_r3, ovf_r3, cnt_sat, ovf_sat);
        end
        checks++;
        if (cnt_wdt !== 10'd0 || ovf_wdt !== 1'b0) begin
            errors++;
            $display("FAIL reset_wdt: count=%0d ovf=%b, expected count=0 ovf=0", cnt_wdt, ovf_wdt);
        end
        rstn = 1'b1;
        en   = 1'b0;
    endtask

    task automatic test_wrap_rate1();
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            step();
            checks++;
            if (cnt_w4 !== 4'(i) || ovf_w4 !== 1'b0) begin
                errors++;
                $display("FAIL wrap1_edge%0d: count=%0d ovf=%b, expected count=%0d ovf=0",
                         i, cnt_w4, ovf_w4, i);
            end
        end
        step();
        checks++;
        if (cnt_w4 !== 4'd0 || ovf_w4 !== 1'b1) begin
            errors++;
            $display("FAIL wrap1_edge16: count=%0d ovf=%b, expected count=0 ovf=1", cnt_w4, ovf_w4);
        end
        en = 1'b0;
    endtask

    task automatic test_rate_step();
        logic [3:0] exp_r3   [5] = '{4'd3, 4'd6, 4'd9, 4'd2, 4'd5};
        logic       exp_or3  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0] exp_sat  [5] = '{4'd3, 4'd6, 4'd9, 4'd9, 4'd9};
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (cnt_r3 !== exp_r3[i] || ovf_r3 !== exp_or3[i]) begin
                errors++;
                $display("FAIL rate3_wrap_edge%0d: count=%0d ovf=%b, expected count=%0d ovf=%b",
                         i + 1, cnt_r3, ovf_r3, exp_r3[i], exp_or3[i]);
            end
            checks++;
            if (cnt_sat !== exp_sat[i] || ovf_sat !== exp_or3[i]) begin
                errors++;
                $display("FAIL rate3_sat_edge%0d: count=%0d ovf=%b, expected count=%0d ovf=%b",
                         i + 1, cnt_sat, ovf_sat, exp_sat[i], exp_or3[i]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_hold_clear();
        do_reset();
        en = 1'b1;
        repeat (5) step();
        // After 5 edges: u_w4 = 5, u_r3 = 3,6,9,2,5 with overflow set.
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (cnt_w4 !== 4'd5 || ovf_w4 !== 1'b0) begin
                errors++;
                $display("FAIL hold_w4_edge%0d: count=%0d ovf=%b, expected count=5 ovf=0",
                         i + 1, cnt_w4, ovf_w4);
            end
        end
        checks++;
        if (cnt_r3 !== 4'd5 || ovf_r3 !== 1'b1) begin
            errors++;
            $display("FAIL hold_r3: count=%0d ovf=%b, expected count=5 ovf=1", cnt_r3, ovf_r3);
        end
        clear = 1'b1;
        en    = 1'b1;
        step();
        checks++;
        if (cnt_w4 !== 4'd0 || ovf_w4 !== 1'b0) begin
            errors++;
            $display("FAIL clear_en_w4: count=%0d ovf=%b, expected count=0 ovf=0", cnt_w4, ovf_w4);
        end
        checks++;
        if (cnt_r3 !== 4'd0 || ovf_r3 !== 1'b0) begin
            errors++;
            $display("FAIL clear_ovf_r3: count=%0d ovf=%b, expected count=0 ovf=0", cnt_r3, ovf_r3);
        end
        clear = 1'b0;
        step();
        checks++;
        if (cnt_w4 !== 4'd1 || cnt_r3 !== 4'd3) begin
            errors++;
            $display("FAIL after_clear: w4=%0d r3=%0d, expected w4=1 r3=3", cnt_w4, cnt_r3);
        end
        en = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        en = 1'b1;
        repeat (23) step();
        checks++;
        if (cnt_w4 !== 4'd7 || ovf_w4 !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre_reset: count=%0d ovf=%b, expected count=7 ovf=1", cnt_w4, ovf_w4);
        end
        rstn  = 1'b0;
        clear = 1'b0;
        step();
        checks++;
        if (cnt_w4 !== 4'd0 || ovf_w4 !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: count=%0d ovf=%b, expected count=0 ovf=0", cnt_w4, ovf_w4);
        end
        rstn = 1'b1;
        step();
        checks++;
        if (cnt_w4 !== 4'd1 || ovf_w4 !== 1'b0) begin
            errors++;
            $display("FAIL mid_restart: count=%0d ovf=%b, expected count=1 ovf=0", cnt_w4, ovf_w4);
        end
        en = 1'b0;
    endtask

    task automatic test_watchdog();
        do_reset();
        en = 1'b1;
        repeat (999) step();
        checks++;
        if (cnt_wdt !== 10'd999 || ovf_wdt !== 1'b0) begin
            errors++;
            $display("FAIL wdt_999: count=%0d ovf=%b, expected count=999 ovf=0", cnt_wdt, ovf_wdt);
        end
        step();
        checks++;
        if (cnt_wdt !== 10'd0 || ovf_wdt !== 1'b1) begin
            errors++;
            $display("FAIL wdt_expire: count=%0d ovf=%b, expected count=0 ovf=1", cnt_wdt, ovf_wdt);
        end
        step();
        checks++;
        if (cnt_wdt !== 10'd1 || ovf_wdt !== 1'b1) begin
            errors++;
            $display("FAIL wdt_sticky: count=%0d ovf=%b, expected count=1 ovf=1", cnt_wdt, ovf_wdt);
        end
        en = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rstn   = 1'b0;
        en     = 1'b0;
        clear  = 1'b0;
        #1;
        test_reset();
        test_wrap_rate1();
        test_rate_step();
        test_hold_clear();
        test_reset_mid();
        test_watchdog();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_up_counter
